// File: rtl/xadc_pwm_seq.sv
// XADC DRP channel sequencer with per-channel IIR smoothing and PWM outputs.
// Each eoc reads one channel over DRP; filtered values drive period-aligned PWM.
module xadc_pwm_seq #(
   parameter int NUM_CH = 4,
   parameter int PWM_BITS = 8,
   parameter logic [NUM_CH*7-1:0] CH_ADDR = {7'h16, 7'h1F, 7'h17, 7'h1E},
   parameter int AVG_SHIFT = 0,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                eoc,
   input  logic [15:0]         drp_do,
   input  logic                drdy,
   output logic                den,
   output logic                dwe,
   output logic [6:0]          daddr,
   output logic [15:0]         di,
   output logic [NUM_CH-1:0]   pwm,
   output logic                smp_valid,
   output logic [3:0]          smp_ch,
   output logic [PWM_BITS-1:0] smp_data,
   output logic                err_timeout
);

   localparam int AW = PWM_BITS + AVG_SHIFT;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, STORE} state_e;

   state_e              state_q, state_d;
   logic [3:0]          ch_q, ch_d, ch_nxt;
   logic [15:0]         cnt_q, cnt_d;
   logic [PWM_BITS-1:0] raw_q, raw_d;
   logic [AW-1:0]       acc_q [NUM_CH];
   logic [AW-1:0]       acc_d [NUM_CH];
   logic [AW-1:0]       acc_cur, acc_new;
   logic [PWM_BITS-1:0] value [NUM_CH];
   logic [PWM_BITS-1:0] duty_q [NUM_CH];
   logic [PWM_BITS-1:0] duty_d [NUM_CH];
   logic [PWM_BITS-1:0] pcnt_q, pcnt_d;
   logic [NUM_CH-1:0]   pwm_q, pwm_d;
   logic                smp_valid_q, smp_valid_d;
   logic [3:0]          smp_ch_q, smp_ch_d;
   logic [PWM_BITS-1:0] smp_data_q, smp_data_d;
   logic                err_q, err_d;
   logic [6:0]          addr_tab [16];
   logic                unused_drp;

   // Only the top PWM_BITS of the 16-bit DRP word are kept.
   assign unused_drp = ^drp_do;

   for (genvar g = 0; g < 16; g++) begin : g_tab
      if (g < NUM_CH) begin : g_on
         assign addr_tab[g] = CH_ADDR[g*7 +: 7];
      end else begin : g_off
         assign addr_tab[g] = 7'h00;
      end
   end

   always_comb begin
      acc_cur = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (ch_q == 4'(i)) acc_cur = acc_q[i];
         value[i] = PWM_BITS'(acc_q[i] >> AVG_SHIFT);
      end
      acc_new = acc_cur - (acc_cur >> AVG_SHIFT) + AW'(raw_q);
      ch_nxt = (ch_q == 4'(NUM_CH - 1)) ? 4'd0 : ch_q + 4'd1;
   end

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      cnt_d       = cnt_q;
      raw_d       = raw_q;
      acc_d       = acc_q;
      smp_valid_d = 1'b0;
      smp_ch_d    = smp_ch_q;
      smp_data_d  = smp_data_q;
      err_d       = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (eoc) state_d = REQ;
         end
         REQ: begin
            state_d = WAIT;
            cnt_d   = '0;
         end
         WAIT: begin
            // drdy takes priority over an expiring timeout
            if (drdy) begin
               raw_d   = drp_do[15 -: PWM_BITS];
               state_d = STORE;
            end else if (cnt_q == 16'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               ch_d    = ch_nxt;
               state_d = IDLE;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         STORE: begin
            for (int i = 0; i < NUM_CH; i++) begin
               if (ch_q == 4'(i)) acc_d[i] = acc_new;
            end
            smp_valid_d = 1'b1;
            smp_ch_d    = ch_q;
            smp_data_d  = PWM_BITS'(acc_new >> AVG_SHIFT);
            ch_d        = ch_nxt;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pcnt_d = pcnt_q + 1'b1;
      for (int i = 0; i < NUM_CH; i++) begin
         duty_d[i] = (pcnt_q == '1) ? value[i] : duty_q[i];
         pwm_d[i]  = (pcnt_q < duty_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         cnt_q       <= '0;
         raw_q       <= '0;
         pcnt_q      <= '0;
         pwm_q       <= '0;
         smp_valid_q <= 1'b0;
         smp_ch_q    <= '0;
         smp_data_q  <= '0;
         err_q       <= 1'b0;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i]  <= '0;
            duty_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         cnt_q       <= cnt_d;
         raw_q       <= raw_d;
         pcnt_q      <= pcnt_d;
         pwm_q       <= pwm_d;
         smp_valid_q <= smp_valid_d;
         smp_ch_q    <= smp_ch_d;
         smp_data_q  <= smp_data_d;
         err_q       <= err_d;
         for (int i = 0; i < NUM_CH; i++) begin
            acc_q[i]  <= acc_d[i];
            duty_q[i] <= duty_d[i];
         end
      end
   end

   assign den         = (state_q == REQ);
   assign dwe         = 1'b0;
   assign di          = 16'h0000;
   assign daddr       = addr_tab[ch_q];
   assign pwm         = pwm_q;
   assign smp_valid   = smp_valid_q;
   assign smp_ch      = smp_ch_q;
   assign smp_data    = smp_data_q;
   assign err_timeout = err_q;

endmodule

// File: doc/xadc_pwm_seq.md
XADC_PWM_SEQ -- requirements
Module: xadc_pwm_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of sequenced XADC channels; legal range 1..16.
REQ-002 Parameter PWM_BITS, default 8, sample bits kept and PWM resolution; legal range 1..12.
REQ-003 Parameter CH_ADDR, default {7'h16,7'h1F,7'h17,7'h1E}, packed NUM_CH*7-bit DRP address table; channel i uses bits [7i+6:7i].
REQ-004 Parameter AVG_SHIFT, default 0, IIR smoothing shift; legal range 0..4; 0 disables smoothing.
REQ-005 Parameter TIMEOUT, default 255, maximum cycles to wait for drdy; legal range 1..65535.
REQ-006 The port list SHALL be exactly as follows:
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- eoc  in  1  XADC end-of-conversion
- drp_do  in  16  XADC DRP read data
- drdy  in  1  XADC DRP data ready
- den  out  1  DRP enable pulse
- dwe  out  1  DRP write enable, constant 0
- daddr  out  7  DRP address
- di  out  16  DRP write data, constant 0
- pwm  out  NUM_CH  per-channel PWM outputs
- smp_valid  out  1  one-cycle pulse, new sample stored
- smp_ch  out  4  channel index of stored sample
- smp_data  out  PWM_BITS  filtered value stored
- err_timeout  out  1  one-cycle pulse, DRP read timed out

Function
REQ-007 Sequencer FSM states SHALL be IDLE, REQ, WAIT, STORE.
REQ-008 IDLE -> REQ on eoc=1; eoc in any other state SHALL be ignored.
REQ-009 REQ lasts exactly one cycle: den=1 and daddr=CH_ADDR[ch]; next state WAIT.
REQ-010 daddr SHALL hold CH_ADDR[ch] in every state, changing only when ch advances.
REQ-011 WAIT: a cycle counter starts at 0; drdy=1 -> STORE, capturing raw = drp_do[15:16-PWM_BITS].
REQ-012 WAIT: counter reaching TIMEOUT without drdy -> IDLE with err_timeout=1 for one cycle; ch advances; nothing is stored.
REQ-013 drdy and timeout in the same cycle: drdy SHALL win.
REQ-014 drdy outside WAIT SHALL be ignored.
REQ-015 STORE (one cycle): acc[ch] <= acc[ch] - (acc[ch]>>AVG_SHIFT) + raw, acc width PWM_BITS+AVG_SHIFT, no overflow possible; value[ch] = acc[ch]>>AVG_SHIFT; next state IDLE.
REQ-016 With AVG_SHIFT=0, value[ch] SHALL equal raw exactly.
REQ-017 smp_valid SHALL pulse the cycle after STORE with smp_ch=ch and smp_data=the new value[ch].
REQ-018 ch SHALL advance on exit from STORE or timeout, wrapping NUM_CH-1 -> 0 (non-power-of-2 NUM_CH included).
REQ-019 Free-running PWM_BITS-wide counter pcnt SHALL wrap 2^PWM_BITS-1 -> 0.
REQ-020 On pcnt==2^PWM_BITS-1, every duty[i] <= value[i], so duty changes only at period boundaries.
REQ-021 pwm[i] = (pcnt < duty[i]), registered: duty 0 gives constant low; duty all-ones gives high for 2^PWM_BITS-1 of every 2^PWM_BITS cycles.
REQ-022 A value update in the same cycle as the duty reload SHALL be picked up by the next reload, not the current one.
REQ-023 dwe and di SHALL be constant 0.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM IDLE, ch=0, all acc/value/duty=0, pcnt=0, den=0, pwm=0, smp_valid=0, err_timeout=0, smp_ch=0, smp_data=0.
REQ-025 Reset asserted mid-transaction SHALL abandon it; a drdy arriving after release with FSM in IDLE is ignored.
REQ-026 After release the first action SHALL be waiting for eoc on channel 0.

Verification
REQ-027 Defaults, eoc pulse, drdy 3 cycles after den with drp_do=16'hAB00 -> den high 1 cycle with daddr=7'h1E; smp_valid with smp_ch=0, smp_data=8'hAB.
REQ-028 Four eoc/drdy rounds with data 8'h00, 8'h40, 8'hFF, 8'h80 -> daddr sequence 1E,17,1F,16,1E; after next period, pwm high-cycle counts per 256 = 0, 64, 255, 128.
REQ-029 drdy withheld, TIMEOUT=10 -> err_timeout pulses 10 cycles after WAIT entry; ch advances; no smp_valid; next den uses the next address.
REQ-030 AVG_SHIFT=2, value 0, three samples of 8'hFF -> smp_data 63, 111, 147.
REQ-031 NUM_CH=3, five rounds -> smp_ch sequence 0,1,2,0,1.
REQ-032 rst_n low during WAIT, then drdy after release -> all outputs 0, no smp_valid, next den only after eoc, with daddr=CH_ADDR[0].
